// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared funct3 encodings, FSM states and access legality helpers
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory req/gnt/rvalid bus between the MEM stage and data memory
interface mem_stage_if #(
    parameter int AddrWidth = 10
);
    logic                 dmem_req;
    logic                 dmem_we;
    logic [AddrWidth-1:0] dmem_addr;
    logic [3:0]           dmem_be;
    logic [31:0]          dmem_wdata;
    logic                 dmem_gnt;
    logic                 dmem_rvalid;
    logic [31:0]          dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - store lane steering, byte enables, fault check and load extension
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] w_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        fault,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    logic       misaligned;
    logic       illegal;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be         = 4'b0000;
        wdata      = w_data;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{w_data[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{w_data[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                be         = 4'b1111;
                misaligned = |addr_lo;
            end
            default: be = 4'b0000;
        endcase

        // Store takes priority when both controls are set, matching dmem_we in the FSM.
        illegal = 1'b0;
        if (mem_write)
            illegal = !store_f3_legal(funct3);
        else if (mem_read)
            illegal = !load_f3_legal(funct3);

        fault = (mem_read | mem_write) & (illegal | misaligned);
    end

    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            default: ld_data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 MEM pipeline stage: load/store FSM over req/gnt/rvalid plus MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        ctrl_mem_read,
    input  logic        ctrl_mem_write,
    input  logic        ctrl_mem_to_reg,
    input  logic        ctrl_write_reg,
    input  logic        ctrl_branch,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] w_data,
    input  logic [4:0]  write_reg,
    mem_stage_if.master dmem,
    output logic        out_valid,
    output logic [31:0] reg_out_mem_wb,
    output logic [4:0]  write_reg_mem_wb,
    output logic        ctrl_branch_mem_wb,
    output logic        ctrl_mem_to_reg_mem_wb,
    output logic        ctrl_write_reg_mem_wb,
    output logic        mem_fault_mem_wb
);
    generate
        if (DataWidth != 32) begin : g_width_check
            $error("mem_stage: DataWidth must be 32");
        end
    endgenerate

    state_e      state;
    logic        kill;
    logic        req_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] alu_q;
    logic [4:0]  wr_q;
    logic        br_q;
    logic        m2r_q;
    logic        cwr_q;

    logic        accept;
    logic        is_mem;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_fault;
    logic [31:0] ld_data;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready & ~flush;
    assign is_mem   = ctrl_mem_read | ctrl_mem_write;

    // A flush withdraws the request in the same cycle rather than waiting for the next edge.
    assign dmem.dmem_req = req_q & ~flush;

    lsu_align u_align (
        .mem_read   (ctrl_mem_read),
        .mem_write  (ctrl_mem_write),
        .funct3     (funct3),
        .addr_lo    (alu_out[1:0]),
        .w_data     (w_data),
        .be         (al_be),
        .wdata      (al_wdata),
        .fault      (al_fault),
        .ld_funct3  (f3_q),
        .ld_addr_lo (lo_q),
        .rdata      (dmem.dmem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= ST_IDLE;
            kill                   <= 1'b0;
            req_q                  <= 1'b0;
            f3_q                   <= 3'b0;
            lo_q                   <= 2'b0;
            alu_q                  <= 32'b0;
            wr_q                   <= 5'b0;
            br_q                   <= 1'b0;
            m2r_q                  <= 1'b0;
            cwr_q                  <= 1'b0;
            dmem.dmem_we           <= 1'b0;
            dmem.dmem_addr         <= '0;
            dmem.dmem_be           <= 4'b0;
            dmem.dmem_wdata        <= 32'b0;
            out_valid              <= 1'b0;
            reg_out_mem_wb         <= 32'b0;
            write_reg_mem_wb       <= 5'b0;
            ctrl_branch_mem_wb     <= 1'b0;
            ctrl_mem_to_reg_mem_wb <= 1'b0;
            ctrl_write_reg_mem_wb  <= 1'b0;
            mem_fault_mem_wb       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q  <= funct3;
                        lo_q  <= alu_out[1:0];
                        alu_q <= alu_out;
                        wr_q  <= write_reg;
                        br_q  <= ctrl_branch;
                        m2r_q <= ctrl_mem_to_reg;
                        cwr_q <= ctrl_write_reg;
                        if (!is_mem || al_fault) begin
                            out_valid              <= 1'b1;
                            reg_out_mem_wb         <= alu_out;
                            write_reg_mem_wb       <= write_reg;
                            ctrl_branch_mem_wb     <= ctrl_branch;
                            ctrl_mem_to_reg_mem_wb <= ctrl_mem_to_reg;
                            ctrl_write_reg_mem_wb  <= ctrl_write_reg & ~al_fault;
                            mem_fault_mem_wb       <= al_fault;
                        end else begin
                            req_q           <= 1'b1;
                            dmem.dmem_we    <= ctrl_mem_write;
                            dmem.dmem_addr  <= alu_out[AddrWidth+1:2];
                            dmem.dmem_be    <= al_be;
                            dmem.dmem_wdata <= al_wdata;
                            state           <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        req_q <= 1'b0;
                        // A load granted in the flush cycle still owes a response we must absorb.
                        if (dmem.dmem_gnt && !dmem.dmem_we) begin
                            kill  <= 1'b1;
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (dmem.dmem_gnt) begin
                        req_q <= 1'b0;
                        if (dmem.dmem_we) begin
                            state                  <= ST_IDLE;
                            out_valid              <= 1'b1;
                            reg_out_mem_wb         <= alu_q;
                            write_reg_mem_wb       <= wr_q;
                            ctrl_branch_mem_wb     <= br_q;
                            ctrl_mem_to_reg_mem_wb <= m2r_q;
                            ctrl_write_reg_mem_wb  <= cwr_q;
                            mem_fault_mem_wb       <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem.dmem_rvalid) begin
                        state <= ST_IDLE;
                        kill  <= 1'b0;
                        if (!(kill || flush)) begin
                            out_valid              <= 1'b1;
                            reg_out_mem_wb         <= ld_data;
                            write_reg_mem_wb       <= wr_q;
                            ctrl_branch_mem_wb     <= br_q;
                            ctrl_mem_to_reg_mem_wb <= m2r_q;
                            ctrl_write_reg_mem_wb  <= cwr_q;
                            mem_fault_mem_wb       <= 1'b0;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic        ctrl_mem_read, ctrl_mem_write, ctrl_mem_to_reg, ctrl_write_reg, ctrl_branch;
    logic [2:0]  funct3;
    logic [31:0] alu_out, w_data;
    logic [4:0]  write_reg;
    logic        out_valid;
    logic [31:0] reg_out_mem_wb;
    logic [4:0]  write_reg_mem_wb;
    logic        ctrl_branch_mem_wb, ctrl_mem_to_reg_mem_wb, ctrl_write_reg_mem_wb, mem_fault_mem_wb;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        cwr;
        logic        m2r;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.AddrWidth(10)) bus ();

    mem_stage #(.AddrWidth(10), .DataWidth(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .flush                  (flush),
        .ctrl_mem_read          (ctrl_mem_read),
        .ctrl_mem_write         (ctrl_mem_write),
        .ctrl_mem_to_reg        (ctrl_mem_to_reg),
        .ctrl_write_reg         (ctrl_write_reg),
        .ctrl_branch            (ctrl_branch),
        .funct3                 (funct3),
        .alu_out                (alu_out),
        .w_data                 (w_data),
        .write_reg              (write_reg),
        .dmem                   (bus),
        .out_valid              (out_valid),
        .reg_out_mem_wb         (reg_out_mem_wb),
        .write_reg_mem_wb       (write_reg_mem_wb),
        .ctrl_branch_mem_wb     (ctrl_branch_mem_wb),
        .ctrl_mem_to_reg_mem_wb (ctrl_mem_to_reg_mem_wb),
        .ctrl_write_reg_mem_wb  (ctrl_write_reg_mem_wb),
        .mem_fault_mem_wb       (mem_fault_mem_wb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("reg_out", reg_out_mem_wb, mon_e.data);
                chk("write_reg_wb", {27'b0, write_reg_mem_wb}, {27'b0, mon_e.rd});
                chk("ctrl_write_reg_wb", {31'b0, ctrl_write_reg_mem_wb}, {31'b0, mon_e.cwr});
                chk("mem_to_reg_wb", {31'b0, ctrl_mem_to_reg_mem_wb}, {31'b0, mon_e.m2r});
                chk("mem_fault", {31'b0, mem_fault_mem_wb}, {31'b0, mon_e.fault});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rdst, input logic cwr, input logic m2r);
        in_valid        = 1'b1;
        ctrl_mem_read   = rd;
        ctrl_mem_write  = wr;
        funct3          = f3;
        alu_out         = addr;
        w_data          = wd;
        write_reg       = rdst;
        ctrl_write_reg  = cwr;
        ctrl_mem_to_reg = m2r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        sb.push_back('{exp, 5'd7, 1'b1, 1'b1, 1'b0});
        issue(1'b1, 1'b0, f3, addr, 32'h0, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        chk({tag, "_req"}, {31'b0, bus.dmem_req}, 32'd1);
        chk({tag, "_addr"}, {22'b0, bus.dmem_addr}, addr >> 2);
        chk({tag, "_we"}, {31'b0, bus.dmem_we}, 32'd0);
        // rvalid alongside gnt carries junk that must not be sampled
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = ~rdata;
        tick();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        tick();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        tick();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0;
        ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0; ctrl_mem_to_reg = 1'b0;
        ctrl_write_reg = 1'b0; ctrl_branch = 1'b0;
        funct3 = 3'b0; alu_out = 32'b0; w_data = 32'b0; write_reg = 5'b0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'b0;
        tick();
        tick();
        chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_be", {28'b0, bus.dmem_be}, 32'd0);
        chk("rst_reg_out", reg_out_mem_wb, 32'd0);
        rst = 1'b0;
        tick();

        // ALU pass-through
        sb.push_back('{32'h1234, 5'd5, 1'b1, 1'b0, 1'b0});
        issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("alu_in_ready", {31'b0, in_ready}, 32'd1);
        chk("alu_no_req", {31'b0, bus.dmem_req}, 32'd0);
        tick();

        // SB at byte 3 with two stalled REQ cycles
        sb.push_back('{32'h3, 5'd0, 1'b0, 1'b0, 1'b0});
        issue(1'b0, 1'b1, F3_B, 32'h003, 32'h0000_00AB, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sb_req", {31'b0, bus.dmem_req}, 32'd1);
        chk("sb_addr", {22'b0, bus.dmem_addr}, 32'd0);
        chk("sb_be", {28'b0, bus.dmem_be}, 32'h8);
        chk("sb_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
        chk("sb_we", {31'b0, bus.dmem_we}, 32'd1);
        chk("sb_ready0", {31'b0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("sb_ready1", {31'b0, in_ready}, 32'd0);
        chk("sb_req_held", {31'b0, bus.dmem_req}, 32'd1);
        tick();
        @(negedge clk);
        chk("sb_ready2", {31'b0, in_ready}, 32'd0);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        @(negedge clk);
        chk("sb_done_ready", {31'b0, in_ready}, 32'd1);
        chk("sb_done_req", {31'b0, bus.dmem_req}, 32'd0);

        do_load("lb",  F3_B,  32'h002, 32'h0080_0000, 32'hFFFF_FF80);
        do_load("lbu", F3_BU, 32'h002, 32'h0080_0000, 32'h0000_0080);
        do_load("lh",  F3_H,  32'h002, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu", F3_HU, 32'h000, 32'h1234_F00D, 32'h0000_F00D);
        do_load("lw",  F3_W,  32'h004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Faults: misaligned word, illegal load funct3, illegal store funct3
        sb.push_back('{32'h6, 5'd9, 1'b0, 1'b1, 1'b1});
        issue(1'b1, 1'b0, F3_W, 32'h006, 32'h0, 5'd9, 1'b1, 1'b1);
        @(negedge clk);
        chk("lw_mis_no_req", {31'b0, bus.dmem_req}, 32'd0);
        tick();
        sb.push_back('{32'h8, 5'd9, 1'b0, 1'b1, 1'b1});
        issue(1'b1, 1'b0, 3'b011, 32'h008, 32'h0, 5'd9, 1'b1, 1'b1);
        @(negedge clk);
        chk("ld_f3_no_req", {31'b0, bus.dmem_req}, 32'd0);
        tick();
        sb.push_back('{32'h20, 5'd0, 1'b0, 1'b0, 1'b1});
        issue(1'b0, 1'b1, F3_BU, 32'h020, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("st_f3_no_req", {31'b0, bus.dmem_req}, 32'd0);
        tick();

        // SH at upper half, granted on first REQ cycle
        sb.push_back('{32'h2, 5'd0, 1'b0, 1'b0, 1'b0});
        issue(1'b0, 1'b1, F3_H, 32'h002, 32'h1234_CDEF, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sh_be", {28'b0, bus.dmem_be}, 32'hC);
        chk("sh_wdata", bus.dmem_wdata, 32'hCDEF_CDEF);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        tick();

        // Flush during REQ before gnt
        issue(1'b1, 1'b0, F3_W, 32'h010, 32'h0, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("fr_req", {31'b0, bus.dmem_req}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fr_req_drop", {31'b0, bus.dmem_req}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fr_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Flush during WAIT; response is swallowed
        issue(1'b1, 1'b0, F3_W, 32'h014, 32'h0, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fw_still_busy", {31'b0, in_ready}, 32'd0);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h5555_AAAA;
        tick();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("fw_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Reset during WAIT, then a stray rvalid
        issue(1'b1, 1'b0, F3_W, 32'h018, 32'h0, 5'd4, 1'b1, 1'b1);
        @(negedge clk);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_be", {28'b0, bus.dmem_be}, 32'd0);
        chk("mid_rst_reg_out", reg_out_mem_wb, 32'd0);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1111_2222;
        tick();
        bus.dmem_rvalid = 1'b0;
        tick();
        tick();
        chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised MEM pipeline stage sitting between the EXE/MEM and MEM/WB boundaries of the RV32 core. Issues loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) to the data memory over a req/gnt/rvalid handshake, steers byte lanes, sign/zero-extends load data and flags misaligned or illegal accesses. Non-memory instructions pass through to the MEM/WB register with one cycle of latency. While a memory access is in flight, the stage stalls upstream through `in_ready`.

## Interface
Parameters:
- `AddrWidth`, 10: word-address bits of data memory; byte address is `alu_out[AddrWidth+1:0]`.
- `DataWidth`, 32: datapath width; only 32 is supported, and any other value is an elaboration error.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an EXE/MEM instruction is present.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `flush` in 1: squash the accepted or pending instruction.
- `ctrl_mem_read`, `ctrl_mem_write`, `ctrl_mem_to_reg`, `ctrl_write_reg`, `ctrl_branch` in 1 each: control signals from EXE/MEM.
- `funct3` in 3: access size and signedness.
- `alu_out` in 32: effective address, or the ALU result for non-memory instructions.
- `w_data` in 32: store data (rs2).
- `write_reg` in 5: destination register.
- `dmem_req` out 1: memory request valid.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out AddrWidth: word address, equal to `alu_out[AddrWidth+1:2]`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-steered store data.
- `dmem_gnt` in 1: request accepted by memory.
- `dmem_rvalid` in 1: load data valid.
- `dmem_rdata` in 32: load data.
- `out_valid` out 1: MEM/WB entry valid. WB applies no backpressure.
- `reg_out_mem_wb` out 32: extended load data, or the ALU result.
- `write_reg_mem_wb` out 5, `ctrl_branch_mem_wb`, `ctrl_mem_to_reg_mem_wb`, `ctrl_write_reg_mem_wb` out 1 each: registered copies of the corresponding inputs.
- `mem_fault_mem_wb` out 1: misaligned access or illegal funct3.

## Operation
- FSM states are IDLE, REQ and WAIT. `in_ready = (state==IDLE)`. An instruction is accepted when `in_valid & in_ready & ~flush`.
- Non-memory instruction accepted in IDLE:
  - The MEM/WB register loads the inputs with `out_valid=1`.
  - The state stays IDLE.
- Fault check at acceptance:
  - Illegal funct3 for a load: 011, 110, 111.
  - Illegal funct3 for a store: anything other than 000, 001, 010.
  - Misaligned halfword: `addr[0]` set.
  - Misaligned word: `addr[1:0]` nonzero.
  - On a fault, no memory request is made. The next cycle gives `out_valid=1`, `mem_fault_mem_wb=1` and `ctrl_write_reg_mem_wb` forced to 0.
- Legal memory access:
  - Latch the request and move to REQ.
  - In REQ, `dmem_req=1` with stable `addr`, `be`, `wdata` and `we` until `dmem_gnt`.
- Store (SB, SH, SW):
  - SB: `wdata={4{b}}`, `be=4'b0001<<addr[1:0]`.
  - SH: `wdata={2{h}}`, `be=4'b0011<<(2*addr[1])`.
  - SW: `be=4'b1111`.
  - On gnt, go to IDLE; the next cycle gives `out_valid=1`.
- Load:
  - On gnt, go to WAIT.
  - On `dmem_rvalid`, select the lane by `addr[1:0]` and extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Write MEM/WB and go to IDLE.
- `out_valid` is a one-cycle pulse per completed instruction; it is 0 on every other cycle.
- `flush` handling:
  - In IDLE: the incoming instruction is dropped.
  - In REQ: drop `dmem_req` on the same cycle, go to IDLE, no `out_valid`. If `gnt` and `flush` arrive together, a store is committed but produces no `out_valid`, and a load goes to WAIT with the kill bit set.
  - In WAIT: set the kill bit and keep waiting for `rvalid`. The response is consumed and discarded, with no `out_valid`.
- `rvalid` outside WAIT is ignored. `gnt` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata` all 0; every `*_mem_wb` output 0; `out_valid` 0; kill bit 0.
- `in_ready` is 1 after reset.
- Latencies from the acceptance edge:
  - Non-memory or fault: 1 cycle.
  - Store: 1 + N cycles, where N is the number of REQ cycles (at least 1).
  - Load: 1 + N + W cycles, where W is the number of WAIT cycles (at least 1). `rvalid` on the cycle of `gnt` is not sampled.
- `rst` asserted mid-access:
  - Immediate return to IDLE.
  - The outstanding memory response is not tracked. The memory is reset by the same `rst`.

## Structure
- Package `mem_stage_pkg` holds:
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum: `ST_IDLE`, `ST_REQ`, `ST_WAIT`.
- One combinational sub-module, `lsu_align`, handles store lane steering, byte-enable generation, load extraction/extension and the fault check. The FSM and pipeline register stay in `mem_stage`.

## Test plan
- ALU op `alu_out=0x1234`, `write_reg=5`, `ctrl_write_reg=1` → next cycle `out_valid=1`, `reg_out=0x1234`, `in_ready` stays 1.
- SB, `addr=0x003`, `w_data=0xAB` → `dmem_req` with `addr=0`, `be=4'b1000`, `wdata=0xABABABAB`. `gnt` after 2 cycles of wait → `out_valid` the following cycle, `in_ready` low throughout.
- LB at `0x002`, `rdata=0x00800000` → `reg_out=0xFFFFFF80`. The same access as LBU → `0x00000080`. LH at `0x002` with `rdata=0x8001xxxx` → `0xFFFF8001`.
- LW at `0x006` → no `dmem_req`; next cycle `out_valid=1`, `mem_fault=1`, `ctrl_write_reg_mem_wb=0`. Load with funct3=011 → same response.
- Flush in REQ before `gnt` → `dmem_req` drops that cycle, no `out_valid`. Flush in WAIT → `rvalid` is consumed, no `out_valid`, `in_ready` returns 1 the next cycle.
- Assert `rst` during WAIT → all outputs 0 immediately. A stray `rvalid` afterwards produces no `out_valid`.
